// File: rtl/paddle_ai_pkg.sv
// Shared paddle/AI geometry constants and the AI state encoding, so the paddle
// and its computer opponent agree on sizes and on the debug state values.
package paddle_ai_pkg;

  localparam int unsigned PADDLE_HEIGHT = 20;
  localparam int unsigned BALL_SIZE     = 8;
  localparam int unsigned PADDLE_SPEED  = 4;
  localparam int unsigned TABLE_TOP     = 0;
  localparam int unsigned TABLE_BOTTOM  = 480;
  localparam int unsigned VMARGIN       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CENTER = 2'd1,
    ST_WAIT   = 2'd2,
    ST_TRACK  = 2'd3
  } ai_state_t;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/paddle_ai_steer.sv
// Combinational steering compare: paddle centre against a target line with a
// symmetric dead-zone band. 12-bit unsigned so no sum can wrap.
module paddle_ai_steer #(
  parameter int unsigned PADDLE_HEIGHT = 20,
  parameter int unsigned DEAD_ZONE     = 4
) (
  input  logic [11:0] tgt,
  input  logic [10:0] paddle_v_pos,
  output logic        up,
  output logic        down
);

  logic [11:0] pc;

  assign pc   = {1'b0, paddle_v_pos} + 12'(PADDLE_HEIGHT / 2);
  assign up   = (tgt + 12'(DEAD_ZONE)) < pc;
  assign down = tgt > (pc + 12'(DEAD_ZONE));

endmodule

// File: rtl/paddle_ai.sv
// Computer paddle opponent: one up/down decision per vblank rising edge.
// Optional frame-skip jitter is enabled by defining PADDLE_AI_JITTER_EN.
module paddle_ai
  import paddle_ai_pkg::*;
#(
  parameter int unsigned PADDLE_HEIGHT = paddle_ai_pkg::PADDLE_HEIGHT,
  parameter int unsigned BALL_SIZE     = paddle_ai_pkg::BALL_SIZE,
  parameter int unsigned CENTER_V      = 240,
  parameter int unsigned DEAD_ZONE     = 4,
  parameter int unsigned REACT_FRAMES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        vblank,
  input  logic [10:0] ball_v_pos,
  input  logic        ball_toward,
  input  logic [10:0] paddle_v_pos,
  output logic        up,
  output logic        down,
  output logic [1:0]  state
);

  ai_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        vblank_p1;
  logic        tick;
  logic [11:0] tgt;
  logic        steer_en;
  logic        steer_up, steer_down;
  logic        skip;

  assign tick  = vblank & ~vblank_p1;
  assign state = state_q;

`ifdef PADDLE_AI_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_step(lfsr_q);
  assign skip   = (state_q == ST_TRACK) && (lfsr_d[2:0] == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= 8'hA5;
    else if (tick) lfsr_q <= lfsr_d;
  end
`else
  assign skip = 1'b0;
`endif

  paddle_ai_steer #(
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .DEAD_ZONE    (DEAD_ZONE)
  ) u_steer (
    .tgt         (tgt),
    .paddle_v_pos(paddle_v_pos),
    .up          (steer_up),
    .down        (steer_down)
  );

  // Decision uses the state held during the frame; the transition lands on the same tick
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt      = 12'(CENTER_V);
    steer_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ball_toward) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(REACT_FRAMES);
        end else begin
          state_d = ST_CENTER;
        end
      end
      ST_CENTER: begin
        steer_en = 1'b1;
        if (ball_toward) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(REACT_FRAMES);
        end
      end
      ST_WAIT: begin
        if (!ball_toward)       state_d = ST_CENTER;
        else if (cnt_q == 4'd0) state_d = ST_TRACK;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      ST_TRACK: begin
        steer_en = 1'b1;
        tgt      = {1'b0, ball_v_pos} + 12'(BALL_SIZE / 2);
        if (!ball_toward) state_d = ST_CENTER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame-stable registers; enable low overrides any tick on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_p1 <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      up        <= 1'b0;
      down      <= 1'b0;
    end else begin
      vblank_p1 <= vblank;
      if (!enable) begin
        state_q <= ST_IDLE;
        up      <= 1'b0;
        down    <= 1'b0;
      end else if (tick) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        up      <= steer_en & ~skip & steer_up;
        down    <= steer_en & ~skip & steer_down;
      end
    end
  end

endmodule

// File: tb/tb_paddle_ai.sv
// Scoreboard bench for paddle_ai: stimulus queues expected {up,down,state}
// per frame tick; a monitor compares one clock after each tick.
module tb_paddle_ai;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CENTER = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_TRACK  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        vblank = 1'b0;
  logic [10:0] ball_v_pos = '0;
  logic        ball_toward = 1'b0;
  logic [10:0] paddle_v_pos = '0;
  logic        up, down;
  logic [1:0]  state;

  paddle_ai dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .vblank      (vblank),
    .ball_v_pos  (ball_v_pos),
    .ball_toward (ball_toward),
    .paddle_v_pos(paddle_v_pos),
    .up          (up),
    .down        (down),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  v;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         passed = 0;
  int         step_id = 0;
  logic       tb_vbq = 1'b0;
  logic       tb_chk = 1'b0;
  logic       force_chk = 1'b0;
  logic [3:0] last_exp = 4'b0;
  logic [1:0] prev_st = S_IDLE;
  logic [7:0] mlfsr = 8'hA5;
  int         skips = 0;

  // Bench-side tick detector: the DUT output is due one clock after each vblank rise
  always @(posedge clk) begin
    tb_chk <= vblank && !tb_vbq;
    tb_vbq <= vblank;
  end

  always @(negedge clk) begin
    exp_t e;
    if (tb_chk || force_chk) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got up=%b down=%b state=%0d, required no output pending",
                 up, down, state);
      end else begin
        e = sb.pop_front();
        if ({up, down, state} === e.v) passed++;
        else $display("FAIL step%0d: got up=%b down=%b state=%0d, required up=%b down=%b state=%0d",
                      e.id, up, down, state, e.v[3], e.v[2], e.v[1:0]);
      end
    end
  end

  task automatic push(input logic eu, input logic ed, input logic [1:0] es);
    exp_t e;
    step_id++;
    e.id = 16'(step_id);
    e.v = {eu, ed, es};
    sb.push_back(e);
    last_exp = e.v;
    prev_st = es;
  endtask

  // One frame: queue the expectation, then raise and drop vblank
  task automatic frame(input logic eu, input logic ed, input logic [1:0] es);
    logic eu2, ed2;
    eu2 = eu;
    ed2 = ed;
`ifdef PADDLE_AI_JITTER_EN
    mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    if (prev_st == S_TRACK && enable && mlfsr[2:0] == 3'd0) begin
      eu2 = 1'b0;
      ed2 = 1'b0;
      skips++;
    end
`endif
    push(eu2, ed2, es);
    @(posedge clk); #1 vblank = 1'b1;
    @(posedge clk); #1 vblank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Check outside a tick, at the next falling edge
  task automatic fcheck(input logic eu, input logic ed, input logic [1:0] es);
    push(eu, ed, es);
    force_chk = 1'b1;
    @(negedge clk);
    #1 force_chk = 1'b0;
  endtask

  task automatic hold_check();
    fcheck(last_exp[3], last_exp[2], last_exp[1:0]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    fcheck(1'b0, 1'b0, S_IDLE);
    @(posedge clk); #1 rst_n = 1'b1;

    // Centering: paddle low, then inside band, then both edges of the band
    enable = 1'b1; ball_toward = 1'b0; paddle_v_pos = 11'd100;
    frame(1'b0, 1'b0, S_CENTER);
    frame(1'b0, 1'b1, S_CENTER);
    paddle_v_pos = 11'd230; frame(1'b0, 1'b0, S_CENTER);
    paddle_v_pos = 11'd236; frame(1'b1, 1'b0, S_CENTER);
    paddle_v_pos = 11'd235; frame(1'b1, 1'b0, S_CENTER);
    paddle_v_pos = 11'd234; frame(1'b0, 1'b0, S_CENTER);
    paddle_v_pos = 11'd226; frame(1'b0, 1'b0, S_CENTER);
    paddle_v_pos = 11'd225; frame(1'b0, 1'b1, S_CENTER);

    // Reaction delay: CENTER decision, 4 WAIT ticks, then tracking
    ball_toward = 1'b1; ball_v_pos = 11'd50; paddle_v_pos = 11'd200;
    frame(1'b0, 1'b1, S_WAIT);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, S_WAIT);
    frame(1'b0, 1'b0, S_TRACK);
    frame(1'b1, 1'b0, S_TRACK);

    // Dead-zone sweep around the ball target
    paddle_v_pos = 11'd100;
    for (int b = 102; b <= 110; b++) begin
      ball_v_pos = 11'(b);
      frame(1'b0, 1'b0, S_TRACK);
    end
    ball_v_pos = 11'd111; frame(1'b0, 1'b1, S_TRACK);
    ball_v_pos = 11'd101; frame(1'b1, 1'b0, S_TRACK);

    // Enable drop between ticks takes effect on the next clock
    enable = 1'b0;
    hold_check();
    @(posedge clk); #1;
    fcheck(1'b0, 1'b0, S_IDLE);
    frame(1'b0, 1'b0, S_IDLE);

    // Re-enable to CENTER, get down=1, then WAIT aborted by ball turning away
    enable = 1'b1; ball_toward = 1'b0;
    frame(1'b0, 1'b0, S_CENTER);
    frame(1'b0, 1'b1, S_CENTER);
    ball_toward = 1'b1; frame(1'b0, 1'b1, S_WAIT);
    ball_toward = 1'b0; frame(1'b0, 1'b0, S_CENTER);
    frame(1'b0, 1'b1, S_CENTER);

    // Asynchronous reset mid-frame while down=1
    #2 rst_n = 1'b0;
    mlfsr = 8'hA5;
    fcheck(1'b0, 1'b0, S_IDLE);
    @(posedge clk); #1 rst_n = 1'b1;
    frame(1'b0, 1'b0, S_CENTER);

    // Back into TRACK far below the ball
    ball_toward = 1'b1; ball_v_pos = 11'd50; paddle_v_pos = 11'd200;
    frame(1'b0, 1'b1, S_WAIT);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, S_WAIT);
    frame(1'b0, 1'b0, S_TRACK);
    frame(1'b1, 1'b0, S_TRACK);
`ifdef PADDLE_AI_JITTER_EN
    for (int i = 0; i < 256; i++) frame(1'b1, 1'b0, S_TRACK);
    $display("jitter: %0d skipped frames in model", skips);
`endif
    ball_toward = 1'b0; frame(1'b1, 1'b0, S_CENTER);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
